// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority-match pipeline.
// Mode encoding selects which end of the request vector wins.
package prio_pkg;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_encoder.sv
// Combinational priority encoder: returns the index of the winning set bit
// (highest for MODE_MSB, lowest for MODE_LSB) and whether any bit was set.
module prio_encoder
    import prio_pkg::*;
#(
    parameter int W     = 8,
    parameter int IDX_W = clog2(W)
) (
    input  logic [W-1:0]     vec,
    input  logic             mode,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Later iterations overwrite earlier ones, so the scan direction decides the winner.
    always_comb begin
        idx = '0;
        any = |vec;
        if (mode == MODE_LSB) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_match_pipe.sv
// Two-stage priority-encode pipeline: stage 1 encodes, stage 2 decodes to
// one-hot and flags a hit on TARGET; a saturating counter tallies delivered hits.
module prio_match_pipe
    import prio_pkg::*;
#(
    parameter int  W      = 8,
    parameter int  TARGET = W - 1,
    parameter int  CNT_W  = 8,
    localparam int IDX_W  = clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [W-1:0]     out_onehot,
    output logic             out_any,
    output logic             out_match,
    output logic [CNT_W-1:0] match_cnt
);

    // Handshake: a beat moves across a port only on a cycle where valid and ready
    // are both high; a producer holding valid keeps its payload stable until then,
    // and a stage loads whenever it is empty or its current contents leave.

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic             s1_any_q, s1_any_d;

    logic             s2_valid_q, s2_valid_d;
    logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
    logic [W-1:0]     s2_onehot_q, s2_onehot_d;
    logic             s2_any_q, s2_any_d;
    logic             s2_match_q, s2_match_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s1_load;
    logic s2_load;

    prio_encoder #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec  (in_data),
        .mode (in_mode),
        .idx  (enc_idx),
        .any  (enc_any)
    );

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load && !rst;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_idx_d    = s1_idx_q;
        s1_any_d    = s1_any_q;
        s2_valid_d  = s2_valid_q;
        s2_idx_d    = s2_idx_q;
        s2_onehot_d = s2_onehot_q;
        s2_any_d    = s2_any_q;
        s2_match_d  = s2_match_q;
        cnt_d       = cnt_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_idx_d = enc_idx;
                s1_any_d = enc_any;
            end
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_idx_d    = s1_idx_q;
                s2_any_d    = s1_any_q;
                s2_onehot_d = s1_any_q ? (W'(1) << s1_idx_q) : '0;
                s2_match_d  = s1_any_q && (s1_idx_q == IDX_W'(TARGET));
            end
        end

        // Saturate rather than wrap so a large count never reads as a small one.
        if (s2_valid_q && out_ready && s2_match_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_any_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_idx_q    <= '0;
            s2_onehot_q <= '0;
            s2_any_q    <= 1'b0;
            s2_match_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_any_q    <= s1_any_d;
            s2_valid_q  <= s2_valid_d;
            s2_idx_q    <= s2_idx_d;
            s2_onehot_q <= s2_onehot_d;
            s2_any_q    <= s2_any_d;
            s2_match_q  <= s2_match_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outputs read as idle for the whole reset cycle, not just after the edge.
    assign out_valid  = s2_valid_q && !rst;
    assign out_idx    = rst ? '0 : s2_idx_q;
    assign out_onehot = rst ? '0 : s2_onehot_q;
    assign out_any    = s2_any_q && !rst;
    assign out_match  = s2_match_q && !rst;
    assign match_cnt  = rst ? '0 : cnt_q;

endmodule
